// File: rtl/upc_loop_profiler_if.sv
`default_nettype none
// ============================================================================
// Module      : upc_loop_profiler_if
// Description : Record stream between the loop profiler and its consumer
//               (CSV dumper or trace buffer). Valid/ready handshake; a record
//               is transferred when rec_valid && rec_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface upc_loop_profiler_if #(
    parameter int W = 97
) ();
    logic         rec_valid;
    logic [W-1:0] rec_data;
    logic         rec_ready;

    modport master (output rec_valid, output rec_data, input rec_ready);
    modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface
`default_nettype wire

// File: rtl/upc_loop_profiler.sv
`default_nettype none
// ============================================================================
// Module      : upc_loop_profiler
// Description : Cycle-accurate profiler for one pipelined HLS loop. Each loop
//               transaction is condensed into a record
//               {complete, ts_start, latency, iters, stalls} and queued in a
//               small first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module upc_loop_profiler #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             loop_start,
    input  wire logic             loop_done,
    input  wire logic             iter_start,
    input  wire logic             iter_end,
    input  wire logic             stall,
    input  wire logic             finish,
    upc_loop_profiler_if.master   rec,
    output logic                  busy,
    output logic [CNT_W-1:0]      txn_count,
    output logic [CNT_W-1:0]      drop_count
);

    localparam int REC_W = 2*TS_W + 2*CNT_W + 1;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [TS_W-1:0]     ts_q;
    logic [TS_W-1:0]     ts_start_q, ts_start_d;
    logic [CNT_W-1:0]    iters_q, iters_d, iters_inc;
    logic [CNT_W-1:0]    stalls_q, stalls_d, stalls_inc;
    logic [TS_W-1:0]     latency;
    logic                push;
    logic                push_complete;
    logic [REC_W-1:0]    push_data;

    logic [REC_W-1:0]    mem [DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                fifo_empty, fifo_full, pop, push_ok;

    // iter_start only qualifies the iteration; it is not counted.
    logic unused_iter_start;
    assign unused_iter_start = iter_start;

    // Free-running timestamp, sticks at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ts_q <= '0;
        else if (ts_q != {TS_W{1'b1}})
            ts_q <= ts_q + TS_W'(1);
    end

    // Counter values including this cycle's events, saturating.
    always_comb begin
        iters_inc  = (iter_end && iters_q != {CNT_W{1'b1}}) ? iters_q + CNT_W'(1) : iters_q;
        stalls_inc = (stall && stalls_q != {CNT_W{1'b1}}) ? stalls_q + CNT_W'(1) : stalls_q;
        latency    = ts_q - ts_start_q;
        push_data  = {push_complete, ts_start_q, latency, iters_inc, stalls_inc};
    end

    // Transaction FSM state and per-transaction accumulators.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ts_start_q <= '0;
            iters_q    <= '0;
            stalls_q   <= '0;
        end else begin
            state_q    <= state_d;
            ts_start_q <= ts_start_d;
            iters_q    <= iters_d;
            stalls_q   <= stalls_d;
        end
    end

    // Next-state logic; finish outranks loop_start, and a coincident
    // loop_done turns the finish push into a normal complete record.
    always_comb begin
        state_d       = state_q;
        ts_start_d    = ts_start_q;
        iters_d       = iters_q;
        stalls_d      = stalls_q;
        push          = 1'b0;
        push_complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (finish) begin
                    state_d = S_HALT;
                end else if (loop_start) begin
                    state_d    = S_RUN;
                    ts_start_d = ts_q;
                    iters_d    = '0;
                    stalls_d   = '0;
                end
            end
            S_RUN: begin
                iters_d  = iters_inc;
                stalls_d = stalls_inc;
                if (loop_done) begin
                    push          = 1'b1;
                    push_complete = 1'b1;
                    if (finish) begin
                        state_d = S_HALT;
                    end else if (loop_start) begin
                        ts_start_d = ts_q;
                        iters_d    = '0;
                        stalls_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (finish) begin
                    push    = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO status; a pop at full frees the slot for a same-cycle push.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = !fifo_empty && rec.rec_ready;
        push_ok    = push && (!fifo_full || pop);
    end

    // Record storage and pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Saturating push/drop statistics.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            txn_count  <= '0;
            drop_count <= '0;
        end else if (push) begin
            if (push_ok) begin
                if (txn_count != {CNT_W{1'b1}})
                    txn_count <= txn_count + CNT_W'(1);
            end else if (drop_count != {CNT_W{1'b1}}) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Head of FIFO drives the stream; data reads zero when nothing is queued.
    always_comb begin
        rec.rec_valid = !fifo_empty;
        rec.rec_data  = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
        busy          = (state_q == S_RUN);
    end

endmodule
`default_nettype wire

// File: tb/tb_upc_loop_profiler.sv
`default_nettype none
// ============================================================================
// Module      : tb_upc_loop_profiler
// Description : Bench for upc_loop_profiler: directed scenarios with literal
//               expectations, then randomized traffic against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_upc_loop_profiler;
    localparam int TS_W  = 32;
    localparam int CNT_W = 16;
    localparam int DEPTH = 4;
    localparam int W     = 2*TS_W + 2*CNT_W + 1;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic loop_start = 1'b0, loop_done = 1'b0, iter_start = 1'b0;
    logic iter_end = 1'b0, stall = 1'b0, finish = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] txn_count, drop_count;

    upc_loop_profiler_if #(.W(W)) rif ();

    upc_loop_profiler #(.TS_W(TS_W), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .loop_start(loop_start), .loop_done(loop_done), .iter_start(iter_start),
        .iter_end(iter_end), .stall(stall), .finish(finish),
        .rec(rif), .busy(busy), .txn_count(txn_count), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    // ---------------- reference model (transaction level) ----------------
    int               m_mode;   // 0 idle, 1 running, 2 halted
    logic [TS_W-1:0]  m_ts, m_start;
    logic [CNT_W-1:0] m_it, m_st, m_txn, m_drop;
    logic [W-1:0]     mq[$];

    function automatic logic [W-1:0] mkrec(input logic c, input logic [TS_W-1:0] s,
                                           input logic [TS_W-1:0] l,
                                           input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] t);
        return {c, s, l, i, t};
    endfunction

    function automatic logic [CNT_W-1:0] csat(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && v != {CNT_W{1'b1}}) ? v + CNT_W'(1) : v;
    endfunction

    function automatic logic [W-1:0] m_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    task automatic m_clear();
        m_mode = 0; m_ts = '0; m_start = '0; m_it = '0; m_st = '0;
        m_txn = '0; m_drop = '0;
        mq.delete();
    endtask

    task automatic m_step();
        logic             pop, push;
        logic [W-1:0]     r;
        logic [CNT_W-1:0] it, st;
        pop  = (mq.size() > 0) && rif.rec_ready;
        push = 1'b0;
        r    = '0;
        it   = csat(m_it, iter_end);
        st   = csat(m_st, stall);
        if (m_mode == 0) begin
            if (finish) m_mode = 2;
            else if (loop_start) begin
                m_mode = 1; m_start = m_ts; m_it = '0; m_st = '0;
            end
        end else if (m_mode == 1) begin
            if (loop_done || finish) begin
                push = 1'b1;
                r    = mkrec(loop_done, m_start, TS_W'(m_ts - m_start), it, st);
            end
            if (finish) m_mode = 2;
            else if (loop_done) begin
                if (loop_start) begin m_start = m_ts; m_it = '0; m_st = '0; end
                else m_mode = 0;
            end else begin
                m_it = it; m_st = st;
            end
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(r);
                m_txn = csat(m_txn, 1'b1);
            end else begin
                m_drop = csat(m_drop, 1'b1);
            end
        end
        if (m_ts != {TS_W{1'b1}}) m_ts = m_ts + TS_W'(1);
    endtask

    initial begin
        m_clear();
        forever begin
            @(posedge clock);
            if (!reset) m_clear();
            else m_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("rst_valid", W'(rif.rec_valid), '0);
                chk("rst_data", rif.rec_data, '0);
                chk("rst_busy", W'(busy), '0);
                chk("rst_txn", W'(txn_count), '0);
                chk("rst_drop", W'(drop_count), '0);
            end else begin
                chk("valid", W'(rif.rec_valid), W'(mq.size() > 0));
                if (mq.size() > 0) chk("data", rif.rec_data, mq[0]);
                chk("busy", W'(busy), W'(m_mode == 1));
                chk("txn", W'(txn_count), W'(m_txn));
                chk("drop", W'(drop_count), W'(m_drop));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_in();
        loop_start = 0; loop_done = 0; iter_start = 0;
        iter_end = 0; stall = 0; finish = 0;
    endtask

    task automatic do_reset();
        clr_in();
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
    endtask

    task automatic wait_ts(input logic [TS_W-1:0] v);
        int n = 0;
        while (m_ts != v && n < 500) begin tick(); n++; end
        vecs++;
        if (m_ts != v) begin
            errs++;
            $display("FAIL wait_ts: timestamp %0d never reached %0d", m_ts, v);
        end
    endtask

    task automatic short_txn();
        loop_start = 1; tick(); loop_start = 0; tick();
        loop_done = 1; tick(); loop_done = 0; tick();
    endtask

    // ---------------- scenarios ----------------
    initial begin
        rif.rec_ready = 1'b0;
        clr_in();
        tick(); tick();
        chk("reset_valid", W'(rif.rec_valid), '0);
        chk("reset_txn", W'(txn_count), '0);
        reset = 1'b1;

        // Single transaction
        wait_ts(10); loop_start = 1; tick(); loop_start = 0;
        for (int i = 0; i < 8; i++) begin
            iter_end = 1; stall = (i < 2); tick();
        end
        clr_in();
        wait_ts(22); loop_done = 1; tick(); loop_done = 0;
        chk("single_rec", rif.rec_data, mkrec(1'b1, 10, 12, 8, 2));
        chk("single_model", m_head(), mkrec(1'b1, 10, 12, 8, 2));
        chk("single_txn", W'(txn_count), W'(1));
        rif.rec_ready = 1; tick(); rif.rec_ready = 0;

        // Back-to-back
        do_reset();
        wait_ts(20); loop_start = 1; tick(); loop_start = 0;
        wait_ts(30); loop_start = 1; loop_done = 1; tick(); clr_in();
        chk("b2b_busy", W'(busy), W'(1));
        wait_ts(35); loop_done = 1; tick(); loop_done = 0;
        chk("b2b_rec0", rif.rec_data, mkrec(1'b1, 20, 10, 0, 0));
        rif.rec_ready = 1; tick(); rif.rec_ready = 0;
        chk("b2b_rec1", rif.rec_data, mkrec(1'b1, 30, 5, 0, 0));
        rif.rec_ready = 1; tick(); rif.rec_ready = 0;

        // Overflow
        do_reset();
        wait_ts(2);
        for (int k = 0; k < 6; k++) short_txn();
        chk("ovf_drop", W'(drop_count), W'(2));
        chk("ovf_txn", W'(txn_count), W'(4));
        for (int k = 0; k < 4; k++) begin
            chk("ovf_order", rif.rec_data, mkrec(1'b1, TS_W'(2 + 4*k), 2, 0, 0));
            rif.rec_ready = 1; tick();
        end
        rif.rec_ready = 0;
        chk("ovf_empty", W'(rif.rec_valid), '0);

        // Finish mid-run
        do_reset();
        wait_ts(5); loop_start = 1; tick(); loop_start = 0;
        iter_end = 1; tick(); tick(); tick(); iter_end = 0;
        finish = 1; tick(); finish = 0;
        chk("fin_rec", rif.rec_data, mkrec(1'b0, 5, 4, 3, 0));
        loop_start = 1; tick(); tick(); loop_start = 0;
        chk("halt_busy", W'(busy), '0);
        chk("halt_txn", W'(txn_count), W'(1));

        // Finish coincident with done
        do_reset();
        wait_ts(11); loop_start = 1; tick(); loop_start = 0;
        wait_ts(15); loop_done = 1; finish = 1; tick(); clr_in();
        tick();
        chk("findone_rec", rif.rec_data, mkrec(1'b1, 11, 4, 0, 0));
        chk("findone_txn", W'(txn_count), W'(1));

        // Asynchronous reset while running with records queued
        do_reset();
        short_txn(); short_txn();
        loop_start = 1; tick(); loop_start = 0;
        chk("pre_rst_busy", W'(busy), W'(1));
        chk("pre_rst_txn", W'(txn_count), W'(2));
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", W'(rif.rec_valid), '0);
        chk("arst_data", rif.rec_data, '0);
        chk("arst_busy", W'(busy), '0);
        chk("arst_txn", W'(txn_count), '0);
        tick(); tick();
        reset = 1'b1;
        wait_ts(3); loop_start = 1; tick(); loop_start = 0;
        wait_ts(7); loop_done = 1; tick(); loop_done = 0;
        chk("post_rst_rec", rif.rec_data, mkrec(1'b1, 3, 4, 0, 0));

        // Randomized traffic
        rif.rec_ready = 0;
        for (int blk = 0; blk < 5; blk++) begin
            do_reset();
            for (int c = 0; c < 600; c++) begin
                loop_start    = ($urandom_range(0, 7) == 0);
                loop_done     = ($urandom_range(0, 9) == 0);
                iter_start    = $urandom_range(0, 1);
                iter_end      = $urandom_range(0, 1);
                stall         = ($urandom_range(0, 3) == 0);
                finish        = ($urandom_range(0, 299) == 0);
                rif.rec_ready = ($urandom_range(0, 9) < 4);
                tick();
            end
        end
        clr_in();
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/upc_loop_profiler.md
Name: upc_loop_profiler

Overview:
- Synthesizable, cycle-accurate profiler that sits directly upstream of the simulation-side sample/dump chain.
- Taps the control signals of one pipelined HLS loop module: ap_start, ap_ready, ap_done_int, iteration start/end qualifiers and the subdone block.
- Condenses each loop transaction into one fixed-width record: start timestamp, latency, iteration count, stall cycles, completion flag.
- Records queue in a small FIFO and drain over a valid/ready interface to the CSV dumper or a trace buffer.

Parameters:
TS_W, 32, width of free-running timestamp and latency fields
CNT_W, 16, width of iteration and stall count fields
DEPTH, 4, record FIFO depth (power of two, >= 2)

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous assert, active-low; deassertion is synchronous to clock
loop_start  in  1  monitored module ap_start
loop_done  in  1  monitored module ap_done_int
iter_start  in  1  iteration-begin qualifier (state==iter_start_state && iter_start_enable && !iter_start_block)
iter_end  in  1  iteration-end qualifier (state==iter_end_state && iter_end_enable && !iter_end_block)
stall  in  1  subdone block asserted while the loop is enabled
finish  in  1  simulation/test finish request
rec_valid  out  1  FIFO head record available
rec_data  out  2*TS_W+2*CNT_W+1  {complete, ts_start, latency, iters, stalls}, MSB first
rec_ready  in  1  consumer accepts head when rec_valid && rec_ready
busy  out  1  FSM in RUN
txn_count  out  CNT_W  records pushed since reset, saturating
drop_count  out  CNT_W  records lost to full FIFO, saturating

Behaviour:
- Reset (reset==0): FSM=IDLE; timestamp, all counters, FIFO pointers = 0; rec_valid=0; rec_data=0; busy=0; txn_count=0; drop_count=0.
- Timestamp: increments every cycle after reset release; saturates at all-ones (no wrap).
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - loop_start=1 -> RUN; ts_start<=timestamp; iters<=0; stalls<=0.
  - iter_end/stall ignored in IDLE.
- RUN:
  - iter_end=1 increments iters (saturating).
  - stall=1 increments stalls (saturating).
  - iter_start is qualification only; not counted.
  - loop_done=1: push record {1, ts_start, timestamp-ts_start, iters', stalls'}. Primes denote values including this cycle's iter_end/stall.
  - Same cycle as loop_done, loop_start=1 (back-to-back): stay RUN, reload ts_start<=timestamp, clear counters.
  - Same cycle as loop_done, loop_start=0: -> IDLE.
- finish=1 (any state except HALT): -> HALT.
  - If in RUN and loop_done=0: push partial record with complete=0, latency=timestamp-ts_start.
  - finish has priority over loop_start.
  - If loop_done=1 in the same cycle: a normal complete record is pushed instead; no second push.
- HALT: ignores all loop inputs until reset; FIFO continues to drain.
- Push latency: record visible on rec_data/rec_valid the cycle after the push event (registered FIFO head).
- FIFO ordering and occupancy:
  - First-word-fall-through.
  - rec_data holds stable while rec_valid && !rec_ready.
  - Push and pop in the same cycle at full is allowed: pop frees the slot, push succeeds, no drop.
  - Push at full with no pop: record discarded, drop_count++, txn_count unchanged.
  - txn_count++ only on successful push.
- Latency field uses TS_W-bit subtraction. Saturation of timestamp freezes growth; no negative results are possible.
- Reset mid-transaction: record in progress and FIFO contents are discarded; no partial record is emitted.

Test Plan:
- Single transaction: start at ts=10, 8 iter_end pulses, 2 stall cycles, done at ts=22 -> one record {1,10,12,8,2}; txn_count=1.
- Back-to-back: done and start together at ts=30 (previous start 20) -> record latency=10; second transaction ts_start=30; busy never drops.
- Overflow: DEPTH=4, rec_ready=0, 6 transactions -> 4 records held, drop_count=2, txn_count=4. Then rec_ready=1 -> 4 records drained in order, rec_valid=0.
- Finish mid-run: start at ts=5, 3 iter_end, finish at ts=9 -> record {0,5,4,3,0}; later loop_start ignored (HALT).
- Finish coincident with done at ts=15 (start ts=11) -> single record with complete=1, latency=4.
- Async reset asserted between clock edges while RUN with 2 records queued -> outputs 0 immediately; after release, timestamp restarts at 0.
